// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port-0 arbiter: read-tag record, read latency and
// lock state encoding.
package sram_arb_pkg;

   localparam int unsigned SRAM_RD_LAT = 2;
   // Tag id field is sized for the largest supported requester count.
   localparam int unsigned MAX_ID_LEN = 8;

   typedef struct packed {
      logic                  valid;
      logic [MAX_ID_LEN-1:0] id;
   } rsp_tag;

   typedef enum logic {
      StIdle   = 1'b0,
      StLocked = 1'b1
   } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: grants the first set request at or above ptr,
// wrapping around. Purely combinational.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   always_comb begin
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      // Outer loop walks priority order; inner loop keeps every select constant.
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && req[j] && (((32'(ptr) + i) % N) == j)) begin
               found     = 1'b1;
               grant[j]  = 1'b1;
               grant_idx = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM wrapper port 0 between NUM_REQ requesters with round-robin
// grants, per-requester burst locking and tagged 2-cycle read responses.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned SIZE_IN_WORDS = 1024,
   parameter int unsigned WORD_SIZE     = 32,
   parameter int unsigned ADDR_LEN      = $clog2(SIZE_IN_WORDS),
   parameter int unsigned ID_LEN        = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ-1:0]              req_lock,
   input  logic [NUM_REQ*ADDR_LEN-1:0]     req_addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0]    req_wdata,
   input  logic [NUM_REQ*(WORD_SIZE/8)-1:0] req_wmask,
   output logic                            sram_nce0,
   output logic                            sram_nwe0,
   output logic [ADDR_LEN-1:0]             sram_addr0,
   output logic [WORD_SIZE-1:0]            sram_wdata0,
   output logic [WORD_SIZE/8-1:0]          sram_wmask0,
   input  logic [WORD_SIZE-1:0]            sram_rdata0,
   output logic                            rsp_valid,
   output logic [ID_LEN-1:0]               rsp_id,
   output logic [WORD_SIZE-1:0]            rsp_data
);

   localparam int unsigned MASK_LEN = WORD_SIZE / 8;

   lock_state_e       state_q;
   logic [ID_LEN-1:0] lock_owner_q;
   logic [ID_LEN-1:0] rr_ptr_q;
   logic [ID_LEN-1:0] rr_ptr_d;
   rsp_tag            tag_q [SRAM_RD_LAT];
   rsp_tag            tag_d;

   logic [NUM_REQ-1:0] rr_grant;
   logic [ID_LEN-1:0]  rr_idx;
   logic               gnt_vld;
   logic [ID_LEN-1:0]  gnt_idx;
   logic               gnt_we;
   logic               gnt_lock;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_LEN)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   always_comb begin
      gnt_vld     = 1'b0;
      gnt_idx     = rr_idx;
      gnt_we      = 1'b0;
      gnt_lock    = 1'b0;
      req_ready   = '0;
      sram_nce0   = 1'b1;
      sram_nwe0   = 1'b1;
      sram_addr0  = '0;
      sram_wdata0 = '0;
      sram_wmask0 = '0;

      // A held lock excludes everyone but the owner, even when the owner is idle.
      if (state_q == StLocked) begin
         gnt_idx = lock_owner_q;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (lock_owner_q == ID_LEN'(k)) gnt_vld = req_valid[k];
         end
      end else begin
         gnt_vld = |rr_grant;
      end
      if (rst) gnt_vld = 1'b0;

      if (gnt_vld) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_LEN'(k)) begin
               req_ready[k] = 1'b1;
               gnt_we       = req_we[k];
               gnt_lock     = req_lock[k];
               sram_addr0   = req_addr[k*ADDR_LEN +: ADDR_LEN];
               sram_wdata0  = req_wdata[k*WORD_SIZE +: WORD_SIZE];
               sram_wmask0  = req_wmask[k*MASK_LEN +: MASK_LEN];
            end
         end
         sram_nce0 = 1'b0;
         sram_nwe0 = !gnt_we;
      end
   end

   always_comb begin
      rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_LEN'(1);
      tag_d.valid = gnt_vld && !gnt_we;
      tag_d.id    = tag_d.valid ? MAX_ID_LEN'(gnt_idx) : '0;
   end

   // While locked only the owner is granted, so the pointer settles at owner+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         lock_owner_q <= '0;
         rr_ptr_q     <= '0;
      end else if (gnt_vld) begin
         rr_ptr_q <= rr_ptr_d;
         if (gnt_lock) begin
            state_q      <= StLocked;
            lock_owner_q <= gnt_idx;
         end else begin
            state_q <= StIdle;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SRAM_RD_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < SRAM_RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   logic unused_tag_id;
   assign unused_tag_id = ^tag_q[SRAM_RD_LAT-1].id;

   assign rsp_valid = tag_q[SRAM_RD_LAT-1].valid;
   assign rsp_id    = tag_q[SRAM_RD_LAT-1].id[ID_LEN-1:0];
   assign rsp_data  = sram_rdata0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a 2-cycle write-first SRAM model.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req_we, req_lock;
   logic [19:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        sram_nce0, sram_nwe0;
   logic [9:0]  sram_addr0;
   logic [31:0] sram_wdata0;
   logic [3:0]  sram_wmask0;
   logic [31:0] sram_rdata0;
   logic        rsp_valid;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_data;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_lock    (req_lock),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_wmask   (req_wmask),
      .sram_nce0   (sram_nce0),
      .sram_nwe0   (sram_nwe0),
      .sram_addr0  (sram_addr0),
      .sram_wdata0 (sram_wdata0),
      .sram_wmask0 (sram_wmask0),
      .sram_rdata0 (sram_rdata0),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data)
   );

   // SRAM wrapper model: write-first, read data registered twice.
   logic [31:0] mem [1024];
   logic [31:0] rd_s1;
   always @(posedge clk) begin
      if (!sram_nce0) begin
         if (!sram_nwe0) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] = sram_wdata0[b*8 +: 8];
         end else begin
            rd_s1 <= mem[sram_addr0];
         end
      end
      sram_rdata0 <= rd_s1;
   end

   typedef struct {
      logic [1:0]  v, we, lk;
      logic [9:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [3:0]  m0, m1;
      logic [1:0]  rdy;
      logic        rv;
      logic        rid;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                               input logic [9:0] a0, input logic [9:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] m0, input logic [3:0] m1,
                               input logic [1:0] rdy, input logic rv, input logic rid,
                               input logic [31:0] rd);
      vec_t t;
      t.v = v; t.we = we; t.lk = lk; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
      t.m0 = m0; t.m1 = m1; t.rdy = rdy; t.rv = rv; t.rid = rid; t.rd = rd;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      req_valid = t.v;
      req_we    = t.we;
      req_lock  = t.lk;
      req_addr  = {t.a1, t.a0};
      req_wdata = {t.d1, t.d0};
      req_wmask = {t.m1, t.m0};
   endtask

   task automatic idle_inputs();
      drive(mk(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0, 4'd0, 4'd0,
               2'b00, 1'b0, 1'b0, 32'd0));
   endtask

   task automatic chk_idle_port(input string nm, input int idx);
      chk({nm, "_ready"}, idx, 32'(req_ready), 32'd0);
      chk({nm, "_nce"}, idx, 32'(sram_nce0), 32'd1);
      chk({nm, "_nwe"}, idx, 32'(sram_nwe0), 32'd1);
   endtask

   initial begin
      vec_t t;
      logic [9:0]  ea;
      logic [31:0] ed;
      logic [3:0]  em;
      logic        enwe;

      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[5]  = 32'hDEAD_BEEF;
      mem[10] = 32'h1111_0000;
      mem[20] = 32'h2222_0000;
      mem[30] = 32'hA000_0030; mem[31] = 32'hA000_0031;
      mem[32] = 32'hA000_0032; mem[33] = 32'hA000_0033;
      mem[40] = 32'h4040_4040; mem[41] = 32'h4141_4141; mem[42] = 32'h4242_4242;

      //            v      we     lk     a0   a1   d0            d1            m0  m1  rdy   rv rid rd
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 0, 0, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 0, 0, 0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 5,   0,   0,            0,            0,  0,  2'b01, 0, 0, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 0, 0, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 0, 32'hDEAD_BEEF));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10,  20,  0,            0,            0,  0,  2'b10, 0, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10,  20,  0,            0,            0,  0,  2'b01, 0, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10,  20,  0,            0,            0,  0,  2'b10, 1, 1, 32'h2222_0000));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 10,  20,  0,            0,            0,  0,  2'b01, 1, 0, 32'h1111_0000));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 1, 32'h2222_0000));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 0, 32'h1111_0000));
      // Lock burst from requester 1 while requester 0 waits.
      tbl.push_back(mk(2'b11, 2'b00, 2'b10, 40,  30,  0,            0,            0,  0,  2'b10, 0, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b10, 40,  31,  0,            0,            0,  0,  2'b10, 0, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b10, 40,  32,  0,            0,            0,  0,  2'b10, 1, 1, 32'hA000_0030));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 40,  33,  0,            0,            0,  0,  2'b10, 1, 1, 32'hA000_0031));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 40,  34,  0,            0,            0,  0,  2'b01, 1, 1, 32'hA000_0032));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 1, 32'hA000_0033));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 0, 32'h4040_4040));
      // Locked owner goes idle; requester 1 must stall.
      tbl.push_back(mk(2'b01, 2'b00, 2'b01, 41,  0,   0,            0,            0,  0,  2'b01, 0, 0, 0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0,   20,  0,            0,            0,  0,  2'b00, 0, 0, 0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0,   20,  0,            0,            0,  0,  2'b00, 1, 0, 32'h4141_4141));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 42,  20,  0,            0,            0,  0,  2'b01, 0, 0, 0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0,   20,  0,            0,            0,  0,  2'b10, 0, 0, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 0, 32'h4242_4242));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 1, 32'h2222_0000));
      // Read-after-write, full mask then byte-0 mask.
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 700, 0,   32'h1234_5678, 0,           4'hF, 0, 2'b01, 0, 0, 0));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 700, 0,   0,            0,            0,  0,  2'b01, 0, 0, 0));
      tbl.push_back(mk(2'b10, 2'b10, 2'b00, 0,   701, 0,            32'h1234_5678, 0, 4'h1, 2'b10, 0, 0, 0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0,   701, 0,            0,            0,  0,  2'b10, 1, 0, 32'h1234_5678));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 0, 0, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0,   0,   0,            0,            0,  0,  2'b00, 1, 1, 32'h0000_0078));

      // Reset with requests pending: port must stay quiet.
      rst = 1'b1;
      drive(mk(2'b11, 2'b00, 2'b00, 5, 20, 0, 0, 0, 0, 2'b00, 0, 0, 0));
      #12;
      chk_idle_port("rst", 0);
      chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 0, 32'(rsp_id), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         t = tbl[i];
         drive(t);
         @(negedge clk);
         ea = 10'd0; ed = 32'd0; em = 4'd0; enwe = 1'b1;
         if (t.rdy == 2'b01) begin
            ea = t.a0; ed = t.d0; em = t.m0; enwe = !t.we[0];
         end else if (t.rdy == 2'b10) begin
            ea = t.a1; ed = t.d1; em = t.m1; enwe = !t.we[1];
         end
         chk("ready", i, 32'(req_ready), 32'(t.rdy));
         chk("nce", i, 32'(sram_nce0), 32'(t.rdy == 2'b00));
         chk("nwe", i, 32'(sram_nwe0), 32'(enwe));
         chk("addr", i, 32'(sram_addr0), 32'(ea));
         chk("wdata", i, sram_wdata0, ed);
         chk("wmask", i, 32'(sram_wmask0), 32'(em));
         chk("rsp_valid", i, 32'(rsp_valid), 32'(t.rv));
         if (t.rv) begin
            chk("rsp_id", i, 32'(rsp_id), 32'(t.rid));
            chk("rsp_data", i, rsp_data, t.rd);
         end
      end

      // Async reset one cycle after a read is accepted: response must be dropped.
      @(posedge clk);
      #1;
      drive(mk(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0));
      @(negedge clk);
      chk("mid_issue_nce", 100, 32'(sram_nce0), 32'd0);
      @(posedge clk);
      #1;
      drive(mk(2'b11, 2'b00, 2'b00, 5, 20, 0, 0, 0, 0, 2'b00, 0, 0, 0));
      #2;
      rst = 1'b1;
      #1;
      chk_idle_port("mid_rst", 101);
      chk("mid_rst_rsp_valid", 101, 32'(rsp_valid), 32'd0);
      chk("mid_rst_rsp_id", 101, 32'(rsp_id), 32'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("mid_rst_hold_rsp", 102 + c, 32'(rsp_valid), 32'd0);
         chk("mid_rst_hold_ready", 102 + c, 32'(req_ready), 32'd0);
      end
      rst = 1'b0;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_rsp", 104 + c, 32'(rsp_valid), 32'd0);
      end

      // First read after reset: pointer back at 0, normal latency.
      @(posedge clk);
      #1;
      drive(mk(2'b11, 2'b00, 2'b00, 5, 20, 0, 0, 0, 0, 2'b01, 0, 0, 0));
      @(negedge clk);
      chk("post_rst_ready", 107, 32'(req_ready), 32'd1);
      chk("post_rst_addr", 107, 32'(sram_addr0), 32'd5);
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      chk("post_rst_rsp_early", 108, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("post_rst_rsp_valid", 109, 32'(rsp_valid), 32'd1);
      chk("post_rst_rsp_id", 109, 32'(rsp_id), 32'd0);
      chk("post_rst_rsp_data", 109, rsp_data, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
